// File: rtl/la_pwrseq.sv
// la_pwrseq: power-domain sequencer driving staggered switch enables, isolation and domain reset.
//   clk        sequencer clock (always-on domain)
//   nreset     asynchronous active-low reset
//   req        1 = domain requested on, 0 = requested off
//   pwr_ack    power-good from the switched domain (asynchronous, synchronized here)
//   sw_en      thermometer-coded switch-group enables, bit k = group k
//   iso_en     1 = isolate domain outputs
//   dom_nreset active-low reset into the switched domain
//   on         domain powered, de-isolated and out of reset
//   busy       sequence in progress
//   err        power-up timeout, held until req drops
module la_pwrseq #(
    parameter int N       = 4,
    parameter int STAGGER = 8,
    parameter int TIMEOUT = 64,
    parameter int CW      = 8,
    parameter     PROP    = "DEFAULT"
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         req,
    input  logic         pwr_ack,
    output logic [N-1:0] sw_en,
    output logic         iso_en,
    output logic         dom_nreset,
    output logic         on,
    output logic         busy,
    output logic         err
);
    if (N < 1 || N > 16 || STAGGER < 1 || TIMEOUT < 1 || STAGGER >= 2**CW || TIMEOUT >= 2**CW) begin : g_bad_params
        $error("la_pwrseq(%s): parameter out of range", PROP);
    end

    typedef enum logic [3:0] {
        S_OFF, S_RAMP, S_WAIT_ACK, S_ISO_REL, S_ON, S_DRAIN, S_ISOLATE, S_SHUTDOWN, S_ERROR
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    ack_q;
    logic          ack_s;
    logic [N-1:0]  sw_step;

    assign ack_s   = ack_q[1];
    // next group on: shift a one in from the LSB, keeping the enables thermometer-coded
    assign sw_step = N'({sw_en, 1'b1});

    always_ff @(posedge clk or negedge nreset)
        if (!nreset) ack_q <= '0;
        else ack_q <= {ack_q[0], pwr_ack};

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state      <= S_OFF;
            cnt        <= '0;
            sw_en      <= '0;
            iso_en     <= 1'b1;
            dom_nreset <= 1'b0;
            on         <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state)
                S_OFF:
                    if (req) begin
                        state <= (N == 1) ? S_WAIT_ACK : S_RAMP;
                        sw_en <= N'(1);
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                S_RAMP:
                    if (!req) begin
                        state <= S_SHUTDOWN;
                        sw_en <= '0;
                    end else if (cnt == CW'(STAGGER - 1)) begin
                        sw_en <= sw_step;
                        cnt   <= '0;
                        if (&sw_step) state <= S_WAIT_ACK;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                S_WAIT_ACK:
                    // abort beats acknowledge, acknowledge beats timeout
                    if (!req) begin
                        state <= S_SHUTDOWN;
                        sw_en <= '0;
                    end else if (ack_s) begin
                        state  <= S_ISO_REL;
                        iso_en <= 1'b0;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        state <= S_ERROR;
                        sw_en <= '0;
                        busy  <= 1'b0;
                        err   <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                S_ISO_REL: begin
                    state      <= S_ON;
                    dom_nreset <= 1'b1;
                    on         <= 1'b1;
                    busy       <= 1'b0;
                end
                S_ON:
                    if (!req) begin
                        state      <= S_DRAIN;
                        dom_nreset <= 1'b0;
                        on         <= 1'b0;
                        busy       <= 1'b1;
                    end
                S_DRAIN: begin
                    state  <= S_ISOLATE;
                    iso_en <= 1'b1;
                end
                S_ISOLATE: begin
                    state <= S_SHUTDOWN;
                    sw_en <= '0;
                end
                S_SHUTDOWN:
                    // the domain must report power lost before a new request is honoured
                    if (!ack_s) begin
                        state <= S_OFF;
                        busy  <= 1'b0;
                    end
                S_ERROR:
                    if (!req) begin
                        state <= S_OFF;
                        err   <= 1'b0;
                    end
                default: begin
                    state      <= S_OFF;
                    sw_en      <= '0;
                    iso_en     <= 1'b1;
                    dom_nreset <= 1'b0;
                    on         <= 1'b0;
                    busy       <= 1'b0;
                    err        <= 1'b0;
                end
            endcase
        end
    end

    a_iso: assert property (@(posedge clk) disable iff (!nreset)
        !iso_en |-> state inside {S_ISO_REL, S_ON, S_DRAIN});
    a_rst: assert property (@(posedge clk) disable iff (!nreset)
        dom_nreset |-> state == S_ON);
    a_therm: assert property (@(posedge clk) disable iff (!nreset)
        ((sw_en + N'(1)) & sw_en) == '0);
    a_on: assert property (@(posedge clk) disable iff (!nreset)
        on |-> &sw_en);
endmodule

// File: doc/la_pwrseq.md
Name: la_pwrseq

Overview:
- Power-domain sequencer. It is the controlling end of a switched supply domain.
- Drives staggered header/footer switch enables, isolation enable and domain reset.
- Receives the domain's power-good acknowledge. That acknowledge is buffered in the switched domain by a supply-aware buffer and is asynchronous to clk.
- Sits in the always-on domain next to the power switches and isolation cells.

Parameters:
- N, 4: number of power-switch groups. Range 1..16.
- STAGGER, 8: cycles between successive switch-group enables. Range 1..2**CW-1.
- TIMEOUT, 64: maximum cycles in WAIT_ACK before the error state. Range 1..2**CW-1.
- CW, 8: width of the internal cycle counter.
- PROP, "DEFAULT": implementation property string. Passed through and functionally ignored.

Ports:
- clk  input  1  sequencer clock, always-on domain.
- nreset  input  1  asynchronous active-low reset.
- req  input  1  1 = domain requested on, 0 = requested off. Synchronous to clk.
- pwr_ack  input  1  power-good from the switched domain. Asynchronous to clk; synchronized internally.
- sw_en  output  N  switch-group enables; bit k enables group k.
- iso_en  output  1  1 = isolate domain outputs.
- dom_nreset  output  1  active-low reset into the switched domain.
- on  output  1  domain powered, de-isolated and out of reset.
- busy  output  1  sequence in progress.
- err  output  1  power-up timeout. Sticky until req is low.

Behaviour:
- Reset: clk and nreset are the only clock and reset. nreset is asynchronous and active-low. Reset asserted forces:
  - state OFF
  - sw_en=0, iso_en=1, dom_nreset=0, on=0, busy=0, err=0
  - counter=0, both ack synchronizer flops=0
- Reset mid-sequence: the same safe values apply immediately, with no intermediate steps.
- Synchronizer: pwr_ack passes through 2 flops to give ack_s, adding 2 cycles of latency. Only ack_s is used.
- Outputs are registered. Values below are those after the clock edge that enters each state.
- OFF: sw_en=0, iso_en=1, dom_nreset=0.
  - req=1 -> RAMP. sw_en=1 (group 0 on), counter=0.
- RAMP: busy=1.
  - Counter increments each cycle.
  - When counter reaches STAGGER-1, the next sw_en bit sets and the counter clears.
  - Bit k therefore sets k*STAGGER edges after RAMP entry.
  - The edge that sets the last bit enters WAIT_ACK with counter=0.
  - N=1: OFF goes directly to WAIT_ACK with sw_en=1.
  - req=0 -> SHUTDOWN. This takes priority over group stepping.
- WAIT_ACK: busy=1. Counter increments.
  - ack_s=1 -> ISO_REL.
  - Else counter==TIMEOUT-1 -> ERROR.
  - ack_s wins over timeout on the same edge.
  - req=0 -> SHUTDOWN. This has priority over both.
- ISO_REL (1 cycle): iso_en=0, dom_nreset still 0. Next edge -> ON unconditionally.
- ON: dom_nreset=1, on=1, busy=0.
  - req=0 -> DRAIN.
  - Loss of ack_s while ON is ignored.
- DRAIN (1 cycle): dom_nreset=0, on=0, busy=1, iso_en still 0. Next edge -> ISOLATE.
- ISOLATE (1 cycle): iso_en=1. Next edge -> SHUTDOWN.
- SHUTDOWN: sw_en=0 (all groups off at once), iso_en=1, dom_nreset=0, busy=1.
  - ack_s=0 -> OFF.
  - No timeout.
  - req ignored until OFF is reached. A req=1 seen in OFF then restarts the sequence.
- ERROR: sw_en=0, iso_en=1, dom_nreset=0, err=1, busy=0.
  - req=0 -> OFF; err clears on that edge.
- Invariants, checked by assertion:
  - iso_en=0 only in ISO_REL, ON, DRAIN.
  - dom_nreset=1 only in ON.
  - sw_en is always thermometer-coded (bits set from LSB upward).
  - on=1 implies sw_en all ones.
- Width rule: the counter is CW bits and never wraps, because STAGGER and TIMEOUT are < 2**CW. Assert this at elaboration.

Test Plan:
- Power-up, N=4, STAGGER=8, TIMEOUT=64: reset released, req=1 at edge E0.
  - Required: sw_en=0001 after E0, 0011 after E0+8, 0111 after E0+16, 1111 after E0+24.
  - pwr_ack=1 at E0+30 -> iso_en=0 after E0+33, on=1 and dom_nreset=1 after E0+34.
- Power-down from ON: req=0 at edge F0.
  - Required: dom_nreset=0, on=0 after F0; iso_en=1 after F0+1; sw_en=0 after F0+2.
  - pwr_ack=0 -> OFF 3 edges later, busy=0.
- Timeout: pwr_ack held 0.
  - Required: err=1, sw_en=0, iso_en=1 exactly 64 edges after WAIT_ACK entry.
  - req=0 -> err=0 next edge.
- Abort: req drops at E0+10, mid-RAMP with sw_en=0011.
  - Required: SHUTDOWN, sw_en=0 after that edge.
  - iso_en stays 1 throughout; dom_nreset never rises.
- Race: ack_s rises on the same edge the counter reaches TIMEOUT-1.
  - Required: ISO_REL entered, err stays 0.
- Async reset asserted while ON.
  - Required: immediately iso_en=1, dom_nreset=0, sw_en=0, on=0.
  - After release with req=1: full ramp restarts from sw_en=0001.
